// File: rtl/vrf_pkg.sv
// -----------------------------------------------------------------------------
// vrf_pkg
// Shared vector-register-file definitions. The write-back address sequencer
// and the read address generator both use this package.
//   - VRF geometry constants (register length, port width, address width)
//   - BEATS_PER_REG : number of DATA_WIDTH beats in one vector register
//   - wb_desc_t     : destination register-group descriptor
//   - wb_seq_state_t: sequencer position state
//   - expand_whole_reg(): descriptor for a whole-register op
// -----------------------------------------------------------------------------
package vrf_pkg;

    localparam int VRF_VLEN          = 16384;
    localparam int VRF_DATA_WIDTH    = 64;
    localparam int VRF_ADDR_WIDTH    = 5;
    localparam int VRF_DESC_DEPTH    = 4;
    localparam int BEATS_PER_REG     = VRF_VLEN / VRF_DATA_WIDTH;
    localparam int VRF_OFF_WIDTH     = $clog2(BEATS_PER_REG);
    localparam int VRF_REG_IDX_WIDTH = 3;

    typedef struct packed {
        logic [VRF_ADDR_WIDTH-1:0]    addr;
        logic [VRF_REG_IDX_WIDTH-1:0] max_reg;
        logic [VRF_OFF_WIDTH-1:0]     max_off;
        logic [VRF_OFF_WIDTH-1:0]     off;
    } wb_desc_t;

    typedef enum logic {
        SEQ_IDLE   = 1'b0,
        SEQ_ACTIVE = 1'b1
    } wb_seq_state_t;

    // A whole-register op covers 2^sew full registers starting at offset 0.
    function automatic wb_desc_t expand_whole_reg(
        input logic [VRF_ADDR_WIDTH-1:0] addr,
        input logic [1:0]                sew
    );
        wb_desc_t d;
        d.addr    = addr;
        d.max_reg = VRF_REG_IDX_WIDTH'((4'd1 << sew) - 4'd1);
        d.max_off = VRF_OFF_WIDTH'(BEATS_PER_REG - 1);
        d.off     = '0;
        return d;
    endfunction

endpackage

// File: rtl/wb_desc_fifo.sv
// -----------------------------------------------------------------------------
// wb_desc_fifo
// Small synchronous FIFO with an occupancy count, used to queue write-back
// descriptors. DEPTH must be a power of two so the pointers wrap naturally.
// Pushes to a full FIFO and pops from an empty FIFO are ignored.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, wdata: write request and data
//   pop        : remove the head entry
//   rdata      : head entry (valid while count != 0)
//   count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module wb_desc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count != CNT_W'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/wb_addr_seq.sv
// -----------------------------------------------------------------------------
// wb_addr_seq
// Write-back address sequencer. Destination register-group descriptors are
// queued at issue; each returning result beat is turned into a registered
// VRF write (address, offset, data, start/end flags) one cycle later.
// One descriptor is retired per vector op, either on the producer's
// beat_end or when the last position of the group is written.
//
// Optional feature (compile-time macro WB_BYTE_MASK_EN):
//   adds beat_be/wr_be byte enables; an all-zero beat_be advances the
//   position without asserting wr_en.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               descriptor push interface (valid/ready)
//   beat_valid/data/end result beats from the functional units
//   wr_en/addr/off/data VRF write port (registered)
//   wr_start, wr_end    first / last write of a descriptor
//   busy                descriptor FIFO non-empty
//   err_mismatch        last position reached without beat_end (pulse)
//   err_orphan          beat arrived with no descriptor queued (pulse)
// -----------------------------------------------------------------------------
module wb_addr_seq
    import vrf_pkg::*;
#(
    parameter int VLEN       = VRF_VLEN,
    parameter int DATA_WIDTH = VRF_DATA_WIDTH,
    parameter int ADDR_WIDTH = VRF_ADDR_WIDTH,
    parameter int OFF_WIDTH  = $clog2(VLEN / DATA_WIDTH),
    parameter int DESC_DEPTH = VRF_DESC_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2:0]              req_max_reg,
    input  logic [OFF_WIDTH-1:0]    req_max_off,
    input  logic [OFF_WIDTH-1:0]    req_off,
    input  logic                    req_whole_reg,
    input  logic [1:0]              req_sew,
    input  logic                    beat_valid,
    input  logic [DATA_WIDTH-1:0]   beat_data,
    input  logic                    beat_end,
`ifdef WB_BYTE_MASK_EN
    input  logic [DATA_WIDTH/8-1:0] beat_be,
    output logic [DATA_WIDTH/8-1:0] wr_be,
`endif
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [OFF_WIDTH-1:0]    wr_off,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_start,
    output logic                    wr_end,
    output logic                    busy,
    output logic                    err_mismatch,
    output logic                    err_orphan
);

    localparam int CNT_W = $clog2(DESC_DEPTH) + 1;

    wb_desc_t        push_desc;
    wb_desc_t        head_desc;
    logic [CNT_W-1:0] fifo_count;
    logic            push;
    logic            pop;

    wb_seq_state_t   state;
    wb_seq_state_t   state_nxt;
    logic [2:0]      cur_reg;
    logic [OFF_WIDTH-1:0] cur_off;
    logic [2:0]      pos_reg;
    logic [OFF_WIDTH-1:0] pos_off;

    logic            beat_take;
    logic            beat_writes;
    logic            is_last;
    logic            retire;
    logic            mismatch;
    logic            orphan;

    // Ready and busy come from the registered count only, so a full FIFO
    // refuses a push even when the head is popped in the same cycle.
    assign req_ready = (fifo_count != CNT_W'(DESC_DEPTH));
    assign busy      = (fifo_count != '0);
    assign push      = req_valid & req_ready;

    // A beat needs a descriptor already at the head; one pushed this cycle
    // is not visible yet.
    assign beat_take = beat_valid & busy;
    assign orphan    = beat_valid & ~busy;

`ifdef WB_BYTE_MASK_EN
    assign beat_writes = |beat_be;
`else
    assign beat_writes = 1'b1;
`endif

    always_comb begin
        if (req_whole_reg) begin
            push_desc = expand_whole_reg(req_addr, req_sew);
        end else begin
            push_desc.addr    = req_addr;
            push_desc.max_reg = req_max_reg;
            push_desc.max_off = req_max_off;
            push_desc.off     = req_off;
        end
    end

    wb_desc_fifo #(
        .WIDTH ($bits(wb_desc_t)),
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_desc),
        .pop   (pop),
        .rdata (head_desc),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pos_* is the position this beat writes: the head's start position
    // from IDLE, otherwise one step past the previous write. The offset
    // wraps at max_off in every register of the group.
    always_comb begin
        state_nxt = state;
        pos_reg   = cur_reg;
        pos_off   = cur_off;
        retire    = 1'b0;
        mismatch  = 1'b0;

        if (state == SEQ_IDLE) begin
            pos_reg = '0;
            pos_off = head_desc.off;
        end else if (cur_off == head_desc.max_off) begin
            pos_reg = cur_reg + 3'd1;
            pos_off = '0;
        end else begin
            pos_off = cur_off + OFF_WIDTH'(1);
        end

        is_last = (pos_reg == head_desc.max_reg) && (pos_off == head_desc.max_off);

        if (beat_take) begin
            retire    = beat_end | is_last;
            mismatch  = is_last & ~beat_end;
            state_nxt = retire ? SEQ_IDLE : SEQ_ACTIVE;
        end

        pop = retire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_reg <= '0;
            cur_off <= '0;
        end else if (beat_take) begin
            cur_reg <= pos_reg;
            cur_off <= pos_off;
        end
    end

    // Address/offset/data only change on a consumed beat, so they hold
    // their last values through idle gaps and orphan beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en        <= 1'b0;
            wr_start     <= 1'b0;
            wr_end       <= 1'b0;
            err_mismatch <= 1'b0;
            err_orphan   <= 1'b0;
            wr_addr      <= '0;
            wr_off       <= '0;
            wr_data      <= '0;
`ifdef WB_BYTE_MASK_EN
            wr_be        <= '0;
`endif
        end else begin
            wr_en        <= beat_take & beat_writes;
            wr_start     <= beat_take & (state == SEQ_IDLE);
            wr_end       <= retire;
            err_mismatch <= mismatch;
            err_orphan   <= orphan;
            if (beat_take) begin
                wr_addr <= head_desc.addr + ADDR_WIDTH'(pos_reg);
                wr_off  <= pos_off;
                wr_data <= beat_data;
`ifdef WB_BYTE_MASK_EN
                wr_be   <= beat_be;
`endif
            end
        end
    end

endmodule
